// File: rtl/gslcd_v1_0_power_seq_if.sv
// Control/status bundle between the AXI register block, the timing generator and the
// panel power sequencer. The sequencer takes the slave side.
interface gslcd_v1_0_power_seq_if #(
    parameter int unsigned C_BL_WIDTH = 8
);
    logic                  ENABLE;
    logic [C_BL_WIDTH-1:0] BL_DUTY;
    logic                  FRAME_START;
    logic                  LCD_PWR_EN;
    logic                  TIMING_EN;
    logic                  LCD_DISP;
    logic                  BL_PWM;
    logic                  READY;
    logic                  BUSY;
    logic [2:0]            STATE;

    modport slave (
        input  ENABLE,
        input  BL_DUTY,
        input  FRAME_START,
        output LCD_PWR_EN,
        output TIMING_EN,
        output LCD_DISP,
        output BL_PWM,
        output READY,
        output BUSY,
        output STATE
    );

    modport master (
        output ENABLE,
        output BL_DUTY,
        output FRAME_START,
        input  LCD_PWR_EN,
        input  TIMING_EN,
        input  LCD_DISP,
        input  BL_PWM,
        input  READY,
        input  BUSY,
        input  STATE
    );
endinterface

// File: rtl/gslcd_v1_0_power_seq.sv
// Panel power/enable sequencer: orders supply, timing enable, DISP and backlight on the way
// up and back down. Settle periods are counted in PCLK cycles or in frames (FRAME_START rises).
// All outputs are registered and change on the same edge as the state register.
module gslcd_v1_0_power_seq #(
    parameter int unsigned C_DELAY_WIDTH      = 20,
    parameter int unsigned C_PWR_DELAY_CYCLES = 660000,
    parameter int unsigned C_BL_DELAY_CYCLES  = 330000,
    parameter int unsigned C_SETTLE_FRAMES    = 2,
    parameter int unsigned C_BL_WIDTH         = 8,
    parameter int unsigned C_BL_PRESCALE      = 128
) (
    input  logic                         PCLK,
    input  logic                         RESETN,
    gslcd_v1_0_power_seq_if.slave        bus
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StPwrUp    = 3'd1,
        StTimingUp = 3'd2,
        StDispUp   = 3'd3,
        StRun      = 3'd4,
        StBlDown   = 3'd5,
        StDispDown = 3'd6,
        StPwrDown  = 3'd7
    } state_e;

    localparam int unsigned LP_PRESC_W = (C_BL_PRESCALE > 1) ? $clog2(C_BL_PRESCALE) : 1;

    localparam logic [C_DELAY_WIDTH-1:0] LP_PWR_LAST = C_DELAY_WIDTH'(C_PWR_DELAY_CYCLES - 1);
    localparam logic [C_DELAY_WIDTH-1:0] LP_BL_LAST  = C_DELAY_WIDTH'(C_BL_DELAY_CYCLES - 1);
    localparam logic [3:0]               LP_FRM_LAST = 4'(C_SETTLE_FRAMES - 1);
    localparam logic [LP_PRESC_W-1:0]    LP_PRE_LAST = LP_PRESC_W'(C_BL_PRESCALE - 1);

    // State and sequencing registers
    state_e                   r_state;
    logic [C_DELAY_WIDTH-1:0] r_timer;
    logic [3:0]               r_frames;
    logic                     r_fs_q;
    logic                     r_dwell_done;

    // Backlight PWM registers
    logic [LP_PRESC_W-1:0]    r_presc;
    logic [C_BL_WIDTH-1:0]    r_pwm_cnt;
    logic [C_BL_WIDTH-1:0]    r_duty;

    // Registered outputs
    logic                     r_pwr_en;
    logic                     r_timing_en;
    logic                     r_disp;
    logic                     r_bl_pwm;
    logic                     r_ready;
    logic                     r_busy;

    // Combinational next-state values
    state_e                   w_state_nxt;
    logic                     w_entry;
    logic                     w_fs_rise;
    logic                     w_pwr_done;
    logic                     w_bl_done;
    logic                     w_frm_done;
    logic                     w_pwr_nxt;
    logic                     w_ten_nxt;
    logic                     w_disp_nxt;
    logic                     w_in_run;
    logic                     w_run_entry;
    logic                     w_step;
    logic                     w_pwm_wrap;
    logic [LP_PRESC_W-1:0]    w_presc_nxt;
    logic [C_BL_WIDTH-1:0]    w_pwm_nxt;
    logic [C_BL_WIDTH-1:0]    w_duty_nxt;
    logic                     w_bl_nxt;

    assign w_fs_rise  = bus.FRAME_START & ~r_fs_q;
    assign w_pwr_done = (r_timer == LP_PWR_LAST);
    assign w_bl_done  = (r_timer == LP_BL_LAST);
    assign w_frm_done = w_fs_rise && (r_frames == LP_FRM_LAST);
    assign w_entry    = (w_state_nxt != r_state);

    // Next-state decode; an abort (ENABLE low) takes priority over a timed or frame exit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StOff: begin
                // Dwell is either already expired or expires on this very edge
                if (bus.ENABLE && (r_dwell_done || w_pwr_done)) begin
                    w_state_nxt = StPwrUp;
                end
            end
            StPwrUp: begin
                if (!bus.ENABLE) begin
                    w_state_nxt = StPwrDown;
                end else if (w_pwr_done) begin
                    w_state_nxt = StTimingUp;
                end
            end
            StTimingUp: begin
                if (!bus.ENABLE) begin
                    w_state_nxt = StPwrDown;
                end else if (w_frm_done) begin
                    w_state_nxt = StDispUp;
                end
            end
            StDispUp: begin
                if (!bus.ENABLE) begin
                    w_state_nxt = StDispDown;
                end else if (w_bl_done) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                if (!bus.ENABLE) begin
                    w_state_nxt = StBlDown;
                end
            end
            StBlDown: begin
                if (w_bl_done) begin
                    w_state_nxt = StDispDown;
                end
            end
            StDispDown: begin
                if (w_frm_done) begin
                    w_state_nxt = StPwrDown;
                end
            end
            StPwrDown: begin
                if (w_pwr_done) begin
                    w_state_nxt = StOff;
                end
            end
            default: w_state_nxt = StOff;
        endcase
    end

    // Output decode from the next state so outputs move with the state register
    always_comb begin
        w_pwr_nxt  = 1'b0;
        w_ten_nxt  = 1'b0;
        w_disp_nxt = 1'b0;
        case (w_state_nxt)
            StOff:      ;
            StPwrUp:    w_pwr_nxt = 1'b1;
            StTimingUp: begin w_pwr_nxt = 1'b1; w_ten_nxt = 1'b1; end
            StDispUp:   begin w_pwr_nxt = 1'b1; w_ten_nxt = 1'b1; w_disp_nxt = 1'b1; end
            StRun:      begin w_pwr_nxt = 1'b1; w_ten_nxt = 1'b1; w_disp_nxt = 1'b1; end
            StBlDown:   begin w_pwr_nxt = 1'b1; w_ten_nxt = 1'b1; w_disp_nxt = 1'b1; end
            StDispDown: begin w_pwr_nxt = 1'b1; w_ten_nxt = 1'b1; end
            StPwrDown:  w_pwr_nxt = 1'b1;
            default:    ;
        endcase
    end

    // PWM next values; counters only run while RUN is held, and are zero on RUN entry
    always_comb begin
        w_in_run    = (r_state == StRun) && (w_state_nxt == StRun);
        w_run_entry = (r_state != StRun) && (w_state_nxt == StRun);
        w_step      = (r_presc == LP_PRE_LAST);
        w_pwm_wrap  = w_in_run && w_step && (r_pwm_cnt == {C_BL_WIDTH{1'b1}});
        w_presc_nxt = '0;
        w_pwm_nxt   = '0;
        if (w_in_run) begin
            if (!w_step) begin
                w_presc_nxt = r_presc + LP_PRESC_W'(1);
                w_pwm_nxt   = r_pwm_cnt;
            end else begin
                w_pwm_nxt   = r_pwm_cnt + C_BL_WIDTH'(1);
            end
        end
        // Duty is shadowed so a mid-period change only lands at the next period start
        w_duty_nxt = r_duty;
        if (w_run_entry || w_pwm_wrap) begin
            w_duty_nxt = bus.BL_DUTY;
        end
        w_bl_nxt = (w_state_nxt == StRun) && (w_pwm_nxt < w_duty_nxt);
    end

    // State register plus registered status outputs
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= StOff;
            r_pwr_en    <= 1'b0;
            r_timing_en <= 1'b0;
            r_disp      <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pwr_en    <= w_pwr_nxt;
            r_timing_en <= w_ten_nxt;
            r_disp      <= w_disp_nxt;
            r_ready     <= (w_state_nxt == StRun);
            r_busy      <= (w_state_nxt != StRun) && (w_state_nxt != StOff);
        end
    end

    // Cycle timer: cleared on every state entry, saturates instead of wrapping
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            r_timer <= '0;
        end else if (w_entry) begin
            r_timer <= '0;
        end else if (r_timer != {C_DELAY_WIDTH{1'b1}}) begin
            r_timer <= r_timer + C_DELAY_WIDTH'(1);
        end
    end

    // Frame counter: counts FRAME_START rising edges since state entry, saturating
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            r_fs_q   <= 1'b0;
            r_frames <= '0;
        end else begin
            r_fs_q <= bus.FRAME_START;
            if (w_entry) begin
                r_frames <= '0;
            end else if (w_fs_rise && (r_frames != 4'hF)) begin
                r_frames <= r_frames + 4'd1;
            end
        end
    end

    // Off-dwell flag: reset leaves it expired so power-up can start on the first edge
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            r_dwell_done <= 1'b1;
        end else if (w_entry && (w_state_nxt == StOff)) begin
            r_dwell_done <= 1'b0;
        end else if ((r_state == StOff) && w_pwr_done) begin
            r_dwell_done <= 1'b1;
        end
    end

    // Backlight prescaler, PWM counter, duty shadow and PWM output
    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_bl_pwm  <= 1'b0;
        end else begin
            r_presc   <= w_presc_nxt;
            r_pwm_cnt <= w_pwm_nxt;
            r_duty    <= w_duty_nxt;
            r_bl_pwm  <= w_bl_nxt;
        end
    end

    assign bus.LCD_PWR_EN = r_pwr_en;
    assign bus.TIMING_EN  = r_timing_en;
    assign bus.LCD_DISP   = r_disp;
    assign bus.BL_PWM     = r_bl_pwm;
    assign bus.READY      = r_ready;
    assign bus.BUSY       = r_busy;
    assign bus.STATE      = r_state;

endmodule
